// File: rtl/decoder_top_if.sv
// Bundle between the decoder and its user: 2-bit select in, four one-hot
// lanes and the lane-disagreement flag out.
interface decoder_top_if;
    logic [1:0] in;
    logic [3:0] out [4];
    logic       mismatch;

    modport master (output in, input out, input mismatch);
    modport slave  (input in, output out, output mismatch);
endinterface

// File: rtl/decoder_top.sv
// Registered 2-to-4 decoder built four independent ways; a registered flag
// reports any lane that disagrees with lane0 or is not one-hot.
module decoder_top (
    input  logic          clk,
    input  logic          rst_n,
    decoder_top_if.slave  bus
);

    logic [3:0] lane0_next;
    logic [3:0] lane1_next;
    logic [3:0] lane2_next;
    logic [3:0] lane3_next;
    logic [3:0] lane_next [4];
    logic [3:0] out_reg   [4];
    logic       mismatch_next;
    logic       mismatch_reg;

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

    always_comb begin
        lane0_next = 4'b0000;
        case (bus.in)
            2'd0:    lane0_next = 4'b0001;
            2'd1:    lane0_next = 4'b0010;
            2'd2:    lane0_next = 4'b0100;
            2'd3:    lane0_next = 4'b1000;
            default: lane0_next = 4'b0000;
        endcase
    end

    assign lane1_next = 4'b0001 << bus.in;

    assign lane2_next[0] = ~bus.in[1] & ~bus.in[0];
    assign lane2_next[1] = ~bus.in[1] &  bus.in[0];
    assign lane2_next[2] =  bus.in[1] & ~bus.in[0];
    assign lane2_next[3] =  bus.in[1] &  bus.in[0];

    always_comb begin
        lane3_next = 4'b0000;
        lane3_next[bus.in] = 1'b1;
    end

    assign lane_next = '{lane0_next, lane1_next, lane2_next, lane3_next};

    // Every lane, lane0 included, must be one-hot and equal to lane0.
    always_comb begin
        mismatch_next = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if ((lane_next[k] != lane0_next) || !is_onehot(lane_next[k]))
                mismatch_next = 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    out_reg[gi] <= 4'b0000;
                else
                    out_reg[gi] <= lane_next[gi];
            end
            assign bus.out[gi] = out_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mismatch_reg <= 1'b0;
        else
            mismatch_reg <= mismatch_next;
    end

    assign bus.mismatch = mismatch_reg;

endmodule

// File: tb/tb_decoder_top.sv
// Randomised and directed checks of decoder_top against a one-cycle-delayed
// behavioural decode model, plus literal expectations at key points.
module tb_decoder_top;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    decoder_top_if bus ();

    decoder_top dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Model: output is 2**in of the value sampled at the last rising edge,
    // zero while reset is asserted.
    logic [3:0] exp_out = 4'b0000;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            exp_out = 4'b0000;
        else
            exp_out = 4'(2 ** int'(bus.in));
    end

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (bus.out[k] !== exp_out) begin
                miscompares++;
                $display("FAIL model lane%0d @%0t: got %b expected %b", k, $time, bus.out[k], exp_out);
            end
        end
        vectors++;
        if (bus.mismatch !== 1'b0) begin
            miscompares++;
            $display("FAIL model mismatch @%0t: got %b expected 0", $time, bus.mismatch);
        end
    end

    task automatic chk_lanes(input string nm, input logic [3:0] want);
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (bus.out[k] !== want) begin
                miscompares++;
                $display("FAIL %s lane%0d @%0t: got %b expected %b", nm, k, $time, bus.out[k], want);
            end
        end
        vectors++;
        if (bus.mismatch !== 1'b0) begin
            miscompares++;
            $display("FAIL %s mismatch @%0t: got %b expected 0", nm, $time, bus.mismatch);
        end
        $display("check %-10s in=%0d out0=%b want=%b t=%0t", nm, bus.in, bus.out[0], want, $time);
    endtask

    logic [3:0] sweep_lit [4];

    initial begin
        sweep_lit[0] = 4'b0001;
        sweep_lit[1] = 4'b0010;
        sweep_lit[2] = 4'b0100;
        sweep_lit[3] = 4'b1000;

        // Reset with in=3 held: outputs clear before and across clock edges.
        bus.in = 2'd3;
        #1 rst_n = 1'b0;
        #1 chk_lanes("reset", 4'b0000);
        repeat (3) @(posedge clk);
        #1 chk_lanes("reset_clk", 4'b0000);

        @(negedge clk);
        bus.in = 2'd0;
        #2 rst_n = 1'b1;

        // Sweep 0..3 on consecutive cycles.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 chk_lanes("sweep", sweep_lit[i]);
            bus.in = 2'(i + 1);
        end

        // Random back-to-back values, checked by the model each cycle.
        repeat (8) begin
            @(posedge clk);
            #1 bus.in = 2'($urandom_range(3));
            $display("random in=%0d t=%0t", bus.in, $time);
        end

        // Hold in=2.
        @(posedge clk);
        #1 bus.in = 2'd2;
        repeat (5) begin
            @(posedge clk);
            #1 chk_lanes("hold", 4'b0100);
        end

        // Asynchronous reset between edges.
        bus.in = 2'd3;
        @(posedge clk);
        #1 chk_lanes("pre_reset", 4'b1000);
        #3 rst_n = 1'b0;
        #1 chk_lanes("async_rst", 4'b0000);
        bus.in = 2'd1;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 chk_lanes("post_rst", 4'b0010);

        // Latency: a change just after an edge only shows on the next edge.
        bus.in = 2'd0;
        @(posedge clk);
        #1 chk_lanes("lat_before", 4'b0001);
        bus.in = 2'd3;
        #3 chk_lanes("lat_hold", 4'b0001);
        @(posedge clk);
        #1 chk_lanes("lat_after", 4'b1000);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decoder_top.md
Name: decoder_top

Overview:
- Registered 2-to-4 binary decoder block that builds four independent implementations of the same one-hot decode in parallel.
- Each implementation drives its own output lane; all four lanes must always agree.
- A registered disagreement flag provides self-checking.
- Sits as a leaf teaching/utility block: the 2-bit select comes in, the one-hot enables go to downstream logic.

Parameters:
- none (widths fixed: 2-bit input, four lanes of 4 bits)

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- in  input  2  binary select code
- out  output  4 lanes x 4 bits (unpacked array out[0..3], each [3:0])  one-hot decode of in, one lane per implementation
- mismatch  output  1  high when the lanes disagree

Behaviour:
- Single clock domain (clk).
- rst_n is asynchronous and active-low: assertion immediately clears all registers; release is sampled on clk.
- Reset values: out[0..3] = 4'b0000 and mismatch = 0.
- Decode function, identical for every lane: out[k][j] = 1 exactly when in == j. Mapping:
  - in=0 -> 4'b0001
  - in=1 -> 4'b0010
  - in=2 -> 4'b0100
  - in=3 -> 4'b1000
- Lane implementations (combinational, each separately coded):
  - lane0: case statement on in, with a default branch giving 4'b0000
  - lane1: left shift of constant 4'b0001 by in
  - lane2: per-bit sum-of-products equations of in[1] and in[0] (e.g. bit0 = ~in[1] & ~in[0])
  - lane3: clear vector, then set bit indexed by in
- Each lane's combinational result is registered on the rising clk edge into out[k]. Latency is exactly 1 cycle from in to out.
- mismatch is registered in the same cycle as out. It is high if any lane result differs from lane0 or is not one-hot.
  - For legal designs mismatch stays 0.
  - It exists for fault injection and verification.
- Unknown handling: in is X/Z only while under reset. Once out of reset, in must be driven; out is undefined for an undriven in. lane0's default branch yields 4'b0000.
- Holding in constant holds out constant; no internal state beyond the output registers.
- Reset mid-operation: out returns to 0 immediately (asynchronously). The first valid decode appears on the first rising edge after rst_n is released.
- Back-to-back changes of in on every cycle are followed cycle by cycle with no bubbles.

Test Plan:
- Reset: rst_n=0 with in=2'b11 -> all out lanes 4'b0000, mismatch=0, regardless of clk.
- Exhaustive sweep: after reset release, drive in=0,1,2,3 on consecutive cycles -> one cycle later each lane shows 0001, 0010, 0100, 1000 in turn; mismatch stays 0.
- Random: 8 random in values at 10-time-unit spacing -> every lane equals 1<<in (previous-cycle sample) and all four lanes are equal.
- Hold: in=2 held 5 cycles -> out stays 4'b0100 on every lane.
- Async reset mid-stream: in=3, out=1000, drop rst_n between edges -> out goes to 0000 immediately. After release, next edge with in=1 -> out=0010.
- Latency check: change in from 0 to 3 just after an edge -> out still 0001 until the next rising edge, then 1000.
